regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/crush_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/regfile_writeback.sv | 170 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crush_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crush_pkg
//  Description : Shared core constants and types: default datapath width,
//                architectural register address width and register count,
//                and the write-back source selector encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package crush_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Which producer owns the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small synchronous FIFO buffering load results ahead of the
//                register-file write port. First-word fall-through: dout
//                always shows the head entry while the FIFO is non-empty.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                push, din       - enqueue request and data (ignored if full)
//                pop             - dequeue request (ignored if empty)
//                dout            - head entry
//                full, empty     - occupancy flags
//                count           - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (r_count == CNT_FULL);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign dout    = mem[r_rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Register-file write-back arbiter with a load-use scoreboard.
//                ALU results have absolute priority; load results are
//                buffered in a small FIFO and drained when the ALU is idle.
//                The single write port is registered. A busy bit per
//                register tracks loads issued but not yet written back.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                alu_valid/alu_rd/alu_data  - ALU result (always accepted)
//                load_valid/load_ready/
//                load_rd/load_data          - load result handshake
//                issue_load/issue_rd        - decode issues a load
//                rs1_addr/rs2_addr          - source operands to check
//                rs1_busy/rs2_busy          - source has a pending load
//                w_enable/w_address/w_data  - register-file write port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
  import crush_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter int LOAD_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_data,
  input  logic            issue_load,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            w_enable,
  output logic [4:0]      w_address,
  output logic [XLEN-1:0] w_data
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;

  // Load FIFO interface
  logic                              fifo_push;
  logic                              fifo_pop;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [ENTRY_W-1:0]                fifo_din;
  logic [ENTRY_W-1:0]                fifo_dout;
  logic [$clog2(LOAD_FIFO_DEPTH):0]  unused_fifo_count;
  reg_addr_t                         head_rd;
  logic [XLEN-1:0]                   head_data;

  // Write-back selection
  wb_src_e                           src;

  // Registered write port
  logic                              r_we;
  reg_addr_t                         r_wa;
  logic [XLEN-1:0]                   r_wd;
  logic                              r_w_is_load;

  // Scoreboard
  logic [NUM_REGS-1:0]               r_busy;
  logic [NUM_REGS-1:0]               busy_next;

  // --------------------------------------------------------------------------
  // Load buffering. load_ready depends only on registered occupancy and the
  // reset input, never on load_valid.
  // --------------------------------------------------------------------------
  assign load_ready = ~reset & ~fifo_full;
  assign fifo_push  = load_valid & load_ready;
  assign fifo_din   = {load_rd, load_data};
  assign {head_rd, head_data} = fifo_dout;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOAD_FIFO_DEPTH)
  ) u_load_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // --------------------------------------------------------------------------
  // Source selection: ALU first, then the oldest buffered load.
  // --------------------------------------------------------------------------
  always_comb begin
    src = SRC_NONE;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_LOAD;
    end
  end

  // The head is consumed whenever it is selected, even when its rd is x0.
  assign fifo_pop = (src == SRC_LOAD);

  // --------------------------------------------------------------------------
  // Registered write port. Writes to x0 are swallowed by forcing the strobe low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_w_is_load <= 1'b0;
    end else begin
      case (src)
        SRC_ALU: begin
          r_we        <= (alu_rd != '0);
          r_wa        <= alu_rd;
          r_wd        <= alu_data;
          r_w_is_load <= 1'b0;
        end
        SRC_LOAD: begin
          r_we        <= (head_rd != '0);
          r_wa        <= head_rd;
          r_wd        <= head_data;
          r_w_is_load <= 1'b1;
        end
        default: begin
          r_we        <= 1'b0;
          r_w_is_load <= 1'b0;
        end
      endcase
    end
  end

  assign w_enable  = r_we;
  assign w_address = r_wa;
  assign w_data    = r_wd;

  // --------------------------------------------------------------------------
  // Scoreboard. A load write on the port clears its bit at the end of that
  // cycle; a new issue to the same register at the same edge overrides the
  // clear, because the new load is still outstanding. Clearing a bit that is
  // already low is harmless, so loads to non-busy registers need no check.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_next = r_busy;
    if (r_we && r_w_is_load) busy_next[r_wa] = 1'b0;
    if (issue_load)          busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= busy_next;
    end
  end

  assign rs1_busy = r_busy[rs1_addr];
  assign rs2_busy = r_busy[rs2_addr];

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Self-checking bench for regfile_writeback. A directed vector
//                table followed by random traffic, both checked every cycle
//                against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        w_enable;
  logic [4:0]  w_address;
  logic [31:0] w_data;

  always #5 clk = ~clk;

  regfile_writeback #(
    .XLEN            (32),
    .LOAD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_rd    (load_rd),
    .load_data  (load_data),
    .issue_load (issue_load),
    .issue_rd   (issue_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .w_enable   (w_enable),
    .w_address  (w_address),
    .w_data     (w_data)
  );

  // chk bits: [0] w_enable, [1] w_address/w_data, [2] load_ready, [3] busy
  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adat;
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    bit          il;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [3:0]  chk;
    bit          ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    bit          elr;
    bit          eb1;
    bit          eb2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ld_t;

  // Behavioural model state
  ld_t         mq[$];
  bit          mbusy[32];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_wload;
  bit          known;

  int n_checks;
  int n_fail;
  int cyc;
  vec_t tab[$];

  function automatic vec_t mk(bit rst, bit av, logic [4:0] ard, logic [31:0] adat,
                              bit lv, logic [4:0] lrd, logic [31:0] ldat,
                              bit il, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                              logic [3:0] chk, bit ewe, logic [4:0] ewa, logic [31:0] ewd,
                              bit elr, bit eb1, bit eb2);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.il = il; v.ird = ird;
    v.r1 = r1; v.r2 = r2; v.chk = chk; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    v.elr = elr; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tab);
    bit          exp_lr;
    bit          clr_en;
    logic [4:0]  clr_rd;
    ld_t         e;

    reset      = v.rst;
    alu_valid  = v.av;
    alu_rd     = v.ard;
    alu_data   = v.adat;
    load_valid = v.lv;
    load_rd    = v.lrd;
    load_data  = v.ldat;
    issue_load = v.il;
    issue_rd   = v.ird;
    rs1_addr   = v.r1;
    rs2_addr   = v.r2;
    #3;

    if (use_tab) begin
      if (v.chk[0]) check("tab_w_enable", {31'd0, w_enable}, {31'd0, v.ewe});
      if (v.chk[1]) begin
        check("tab_w_enable", {31'd0, w_enable}, 32'd1);
        check("tab_w_address", {27'd0, w_address}, {27'd0, v.ewa});
        check("tab_w_data", w_data, v.ewd);
      end
      if (v.chk[2]) check("tab_load_ready", {31'd0, load_ready}, {31'd0, v.elr});
      if (v.chk[3]) begin
        check("tab_rs1_busy", {31'd0, rs1_busy}, {31'd0, v.eb1});
        check("tab_rs2_busy", {31'd0, rs2_busy}, {31'd0, v.eb2});
      end
    end

    exp_lr = !v.rst && (mq.size() < DEPTH);
    if (known) begin
      check("mdl_w_enable", {31'd0, w_enable}, {31'd0, m_we});
      if (m_we) begin
        check("mdl_w_address", {27'd0, w_address}, {27'd0, m_wa});
        check("mdl_w_data", w_data, m_wd);
      end
      check("mdl_load_ready", {31'd0, load_ready}, {31'd0, exp_lr});
      check("mdl_rs1_busy", {31'd0, rs1_busy}, {31'd0, mbusy[v.r1]});
      check("mdl_rs2_busy", {31'd0, rs2_busy}, {31'd0, mbusy[v.r2]});
    end

    @(posedge clk);
    cyc++;
    if (v.rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_wload = 1'b0;
      known = 1'b1;
    end else begin
      clr_en = m_we && m_wload;
      clr_rd = m_wa;
      if (v.av) begin
        m_we = (v.ard != 0); m_wa = v.ard; m_wd = v.adat; m_wload = 1'b0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = (e.rd != 0); m_wa = e.rd; m_wd = e.d; m_wload = 1'b1;
      end else begin
        m_we = 1'b0; m_wload = 1'b0;
      end
      if (v.lv && exp_lr) begin
        e.rd = v.lrd; e.d = v.ldat;
        mq.push_back(e);
      end
      if (clr_en) mbusy[clr_rd] = 1'b0;
      if (v.il && v.ird != 0) mbusy[v.ird] = 1'b1;
    end
    #1;
  endtask

  initial begin
    vec_t r;
    n_checks = 0; n_fail = 0; cyc = 0; known = 1'b0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_wload = 1'b0;
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    load_valid = 1'b0; load_rd = '0; load_data = '0;
    issue_load = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;

    //          rst av ard adat          lv lrd ldat          il ird r1 r2 chk      we wa wd            lr b1 b2
    tab.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b0000, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b1101, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b1101, 0, 0, 32'h0,        1, 0, 0));
    tab.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,       0, 0, 0, 0, 4'b0101, 0, 0, 32'h0,        1, 0, 0));
    tab.push_back(mk(0, 1, 0, 32'h55,       0, 0,  32'h0,       0, 0, 0, 0, 4'b0011, 1, 5, 32'hDEADBEEF, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b0001, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       1, 7, 7, 0, 4'b1001, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1, 7,  32'h1234,    0, 0, 7, 0, 4'b1100, 0, 0, 32'h0,        1, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 7, 0, 4'b1001, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 7, 0, 4'b1011, 1, 7, 32'h1234,     0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 7, 0, 4'b1001, 0, 0, 32'h0,        0, 0, 0));
    // ALU busy for 4 cycles while 3 loads are offered
    tab.push_back(mk(0, 1, 1, 32'h11,       1, 10, 32'hA0,      0, 0, 0, 0, 4'b0101, 0, 0, 32'h0,        1, 0, 0));
    tab.push_back(mk(0, 1, 2, 32'h22,       1, 11, 32'hA1,      0, 0, 0, 0, 4'b0111, 1, 1, 32'h11,       1, 0, 0));
    tab.push_back(mk(0, 1, 3, 32'h33,       1, 12, 32'hA2,      0, 0, 0, 0, 4'b0111, 1, 2, 32'h22,       0, 0, 0));
    tab.push_back(mk(0, 1, 4, 32'h44,       1, 12, 32'hA2,      0, 0, 0, 0, 4'b0111, 1, 3, 32'h33,       0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1, 12, 32'hA2,      0, 0, 0, 0, 4'b0111, 1, 4, 32'h44,       0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1, 12, 32'hA2,      0, 0, 0, 0, 4'b0111, 1, 10, 32'hA0,      1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b0011, 1, 11, 32'hA1,      0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b0111, 1, 12, 32'hA2,      1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 0, 4'b0101, 0, 0, 32'h0,        1, 0, 0));
    // Re-issue to rd 9 on the same edge its pending load retires
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       1, 9, 0, 0, 4'b0001, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1, 9,  32'h99,      0, 0, 9, 0, 4'b1000, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0, 4'b1001, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       1, 9, 9, 0, 4'b1011, 1, 9, 32'h99,       0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0, 4'b1001, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        1, 9,  32'h77,      0, 0, 9, 0, 4'b1000, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0, 4'b1000, 0, 0, 32'h0,        0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0, 4'b1011, 1, 9, 32'h77,       0, 1, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 9, 0, 4'b1000, 0, 0, 32'h0,        0, 0, 0));
    // Reset with two buffered loads and busy[3] set
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       1, 3, 0, 0, 4'b0000, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 1, 1, 32'h1,        1, 3,  32'h33,      0, 0, 0, 3, 4'b1000, 0, 0, 32'h0,        0, 0, 1));
    tab.push_back(mk(0, 1, 1, 32'h1,        1, 4,  32'h44,      0, 0, 0, 3, 4'b1100, 0, 0, 32'h0,        1, 0, 1));
    tab.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 3, 4'b1111, 1, 1, 32'h1,        0, 0, 1));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 3, 4'b1101, 0, 0, 32'h0,        1, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 3, 4'b0001, 0, 0, 32'h0,        0, 0, 0));
    tab.push_back(mk(0, 0, 0, 32'h0,        0, 0,  32'h0,       0, 0, 0, 3, 4'b0001, 0, 0, 32'h0,        0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++) run_cycle(tab[i], 1'b1);

    // Random traffic; small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
      r.rst  = ($urandom_range(0, 99) == 0);
      r.av   = ($urandom_range(0, 1) == 1);
      r.ard  = 5'($urandom_range(0, 7));
      r.adat = $urandom;
      r.lv   = ($urandom_range(0, 1) == 1);
      r.lrd  = 5'($urandom_range(0, 7));
      r.ldat = $urandom;
      r.il   = ($urandom_range(0, 2) == 0);
      r.ird  = 5'($urandom_range(0, 7));
      r.r1   = 5'($urandom_range(0, 7));
      r.r2   = 5'($urandom_range(0, 7));
      run_cycle(r, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
